// File: rtl/stream_demux4_pkg.sv
// Shared types and constants for the stream_demux4 one-to-four registered demultiplexer.
package stream_demux4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int N_DEF  = 32;
    localparam int CW_DEF = 16;
    localparam int SW     = 2;

endpackage

// File: rtl/stream_demux4_if.sv
// Upstream word handshake plus the four downstream valid/ready/data lanes of stream_demux4.
interface stream_demux4_if #(
    parameter int N = stream_demux4_pkg::N_DEF
);
    logic                             IN_VALID;
    logic                             IN_READY;
    logic [stream_demux4_pkg::SW-1:0] S;
    logic [N-1:0]                     D;
    logic [3:0]                       V;
    logic [3:0]                       R;
    logic [N-1:0]                     Y0;
    logic [N-1:0]                     Y1;
    logic [N-1:0]                     Y2;
    logic [N-1:0]                     Y3;

    modport master (
        output IN_VALID, S, D, R,
        input  IN_READY, V, Y0, Y1, Y2, Y3
    );

    modport slave (
        input  IN_VALID, S, D, R,
        output IN_READY, V, Y0, Y1, Y2, Y3
    );
endinterface

// File: rtl/stream_demux4_xfer_counter.sv
// Wrapping transfer counter with synchronous active-low clear; only built with STREAM_DEMUX4_CNT_EN.
`ifdef STREAM_DEMUX4_CNT_EN
module xfer_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/stream_demux4.sv
// One-entry registered demux: each accepted word is presented on lane S until that lane takes it.
// Optional per-lane completed-transfer counters CNT0..CNT3 are built when STREAM_DEMUX4_CNT_EN is defined.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic            ENABLE,
    stream_demux4_if.slave  bus
`ifdef STREAM_DEMUX4_CNT_EN
    ,
    output logic [CW-1:0]   CNT0,
    output logic [CW-1:0]   CNT1,
    output logic [CW-1:0]   CNT2,
    output logic [CW-1:0]   CNT3
`endif
);

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    data_q;
    logic [SW-1:0]   sel_q;
    logic            sel_rdy;
    logic            in_xfer;
    logic            out_xfer;
    logic            in_ready;
    logic [3:0]      v;
    logic [N-1:0]    y0;
    logic [N-1:0]    y1;
    logic [N-1:0]    y2;
    logic [N-1:0]    y3;

    // Only the ready bit of the lane currently holding the word matters.
    assign sel_rdy  = bus.R[sel_q];
    assign in_xfer  = bus.IN_VALID && in_ready;
    assign out_xfer = RESET_N && ENABLE && (state_q == HOLD) && sel_rdy;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (in_xfer) begin
            data_q <= bus.D;
            sel_q  <= bus.S;
        end
    end

    // In HOLD an input transfer implies the held word drains in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer) state_d = HOLD;
            HOLD:    if (out_xfer && !in_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = RESET_N && ENABLE && ((state_q == IDLE) || sel_rdy);
        v        = 4'b0000;
        y0       = '0;
        y1       = '0;
        y2       = '0;
        y3       = '0;
        if (RESET_N && (state_q == HOLD)) begin
            v[sel_q] = 1'b1;
            case (sel_q)
                2'd0:    y0 = data_q;
                2'd1:    y1 = data_q;
                2'd2:    y2 = data_q;
                default: y3 = data_q;
            endcase
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.V        = v;
    assign bus.Y0       = y0;
    assign bus.Y1       = y1;
    assign bus.Y2       = y2;
    assign bus.Y3       = y3;

`ifdef STREAM_DEMUX4_CNT_EN
    logic [3:0] cnt_inc;

    assign cnt_inc[0] = out_xfer && (sel_q == 2'd0);
    assign cnt_inc[1] = out_xfer && (sel_q == 2'd1);
    assign cnt_inc[2] = out_xfer && (sel_q == 2'd2);
    assign cnt_inc[3] = out_xfer && (sel_q == 2'd3);

    xfer_counter #(.CW(CW)) u_cnt0 (.clk(CLOCK), .rst_n(RESET_N), .inc(cnt_inc[0]), .cnt(CNT0));
    xfer_counter #(.CW(CW)) u_cnt1 (.clk(CLOCK), .rst_n(RESET_N), .inc(cnt_inc[1]), .cnt(CNT1));
    xfer_counter #(.CW(CW)) u_cnt2 (.clk(CLOCK), .rst_n(RESET_N), .inc(cnt_inc[2]), .cnt(CNT2));
    xfer_counter #(.CW(CW)) u_cnt3 (.clk(CLOCK), .rst_n(RESET_N), .inc(cnt_inc[3]), .cnt(CNT3));
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: directed scenarios plus a randomized run against a one-slot queue model.
module tb_stream_demux4;
    import stream_demux4_pkg::*;

    localparam int N  = 32;
    localparam int CW = 4;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    logic ENABLE  = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    stream_demux4_if #(.N(N)) bus ();

`ifdef STREAM_DEMUX4_CNT_EN
    logic [CW-1:0] CNT0, CNT1, CNT2, CNT3;
    stream_demux4 #(.N(N), .CW(CW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .bus(bus),
        .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
    );
`else
    stream_demux4 #(.N(N), .CW(CW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .bus(bus)
    );
`endif

    always #5 CLOCK = ~CLOCK;

    // Reference: a queue that can hold at most one word, drained by its lane's ready.
    typedef struct {
        logic [1:0]   s;
        logic [N-1:0] d;
    } word_t;

    word_t q[$];
    int    cnt[4];

    function automatic logic exp_ready();
        return RESET_N && ENABLE && ((q.size() == 0) || bus.R[q[0].s]);
    endfunction

    function automatic logic [3:0] exp_v();
        if (!RESET_N || q.size() == 0) return 4'b0000;
        return 4'b0001 << q[0].s;
    endfunction

    function automatic logic [N-1:0] exp_y(input int k);
        if (!RESET_N || q.size() == 0) return '0;
        return (int'(q[0].s) == k) ? q[0].d : '0;
    endfunction

    function automatic logic [N-1:0] get_y(input int k);
        case (k)
            0:       return bus.Y0;
            1:       return bus.Y1;
            2:       return bus.Y2;
            default: return bus.Y3;
        endcase
    endfunction

    task automatic model_step();
        logic rdy;
        if (!RESET_N) begin
            q.delete();
            for (int k = 0; k < 4; k++) cnt[k] = 0;
        end else if (ENABLE) begin
            rdy = exp_ready();
            if (q.size() > 0 && bus.R[q[0].s]) begin
                cnt[q[0].s] = cnt[q[0].s] + 1;
                void'(q.pop_front());
            end
            if (bus.IN_VALID && rdy) q.push_back('{s: bus.S, d: bus.D});
        end
    endtask

    initial forever begin
        @(posedge CLOCK);
        model_step();
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_on) begin
            chk("cyc_in_ready", {31'd0, bus.IN_READY}, {31'd0, exp_ready()});
            chk("cyc_v", {28'd0, bus.V}, {28'd0, exp_v()});
            for (int k = 0; k < 4; k++) chk($sformatf("cyc_y%0d", k), get_y(k), exp_y(k));
`ifdef STREAM_DEMUX4_CNT_EN
            chk("cyc_cnt0", N'(CNT0), N'(cnt[0] % (1 << CW)));
            chk("cyc_cnt1", N'(CNT1), N'(cnt[1] % (1 << CW)));
            chk("cyc_cnt2", N'(CNT2), N'(cnt[2] % (1 << CW)));
            chk("cyc_cnt3", N'(CNT3), N'(cnt[3] % (1 << CW)));
`endif
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [N-1:0] vals [4];
        vals = '{32'd1, 32'd2, 32'd3, 32'd5};
        bus.IN_VALID = 1'b0;
        bus.S        = 2'd0;
        bus.D        = '0;
        bus.R        = 4'b0000;

        // Reset with ENABLE high: ready must still be low.
        ENABLE = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_v", {28'd0, bus.V}, 32'd0);
        chk("rst_y3", bus.Y3, 32'd0);
        chk("rst_ready", {31'd0, bus.IN_READY}, 32'd0);
        RESET_N = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, bus.IN_READY}, 32'd1);

        // Single transfer to lane 3.
        bus.D = 32'h5; bus.S = 2'b11; bus.R = 4'b1000; bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        chk("single_v", {28'd0, bus.V}, 32'h8);
        chk("single_y3", bus.Y3, 32'h5);
        chk("single_y0", bus.Y0, 32'h0);
        chk("single_y1", bus.Y1, 32'h0);
        chk("single_y2", bus.Y2, 32'h0);
        tick();
        chk("single_idle_v", {28'd0, bus.V}, 32'd0);

        // Backpressure on lane 1.
        bus.R = 4'b0000; bus.D = 32'h2; bus.S = 2'b01; bus.IN_VALID = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_v", {28'd0, bus.V}, 32'h2);
            chk("bp_y1", bus.Y1, 32'h2);
            chk("bp_ready", {31'd0, bus.IN_READY}, 32'd0);
            tick();
        end
        bus.IN_VALID = 1'b0; bus.R = 4'b0010;
        #1;
        chk("bp_release_ready", {31'd0, bus.IN_READY}, 32'd1);
        tick();
        chk("bp_done_v", {28'd0, bus.V}, 32'd0);

        // Streaming across all four lanes, one word per cycle.
        bus.R = 4'b1111; bus.IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.D = vals[i]; bus.S = 2'(i);
            tick();
            chk("stream_v", {28'd0, bus.V}, 32'd1 << i);
            chk("stream_y", get_y(i), vals[i]);
        end
        bus.IN_VALID = 1'b0;
        tick();
        chk("stream_end_v", {28'd0, bus.V}, 32'd0);

        // ENABLE low freezes a held word even with ready asserted.
        bus.R = 4'b0000; bus.D = 32'h7; bus.S = 2'd2; bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0; ENABLE = 1'b0; bus.R = 4'b0100;
        tick();
        tick();
        chk("en_v", {28'd0, bus.V}, 32'h4);
        chk("en_y2", bus.Y2, 32'h7);
        chk("en_ready", {31'd0, bus.IN_READY}, 32'd0);
        ENABLE = 1'b1;
        #1;
        chk("en_up_ready", {31'd0, bus.IN_READY}, 32'd1);
        tick();
        chk("en_done_v", {28'd0, bus.V}, 32'd0);

        // Reset discards a held word.
        bus.R = 4'b0000; bus.D = 32'h9; bus.S = 2'd2; bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        chk("mid_hold_v", {28'd0, bus.V}, 32'h4);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.IN_READY}, 32'd0);
        tick();
        chk("mid_rst_v", {28'd0, bus.V}, 32'd0);
        chk("mid_rst_y2", bus.Y2, 32'd0);
        chk("mid_rst_ready2", {31'd0, bus.IN_READY}, 32'd0);
        RESET_N = 1'b1;
        #1;
        chk("mid_rel_ready", {31'd0, bus.IN_READY}, {31'd0, ENABLE});

`ifdef STREAM_DEMUX4_CNT_EN
        // 17 transfers to lane 2 wrap the 4-bit counter to 1.
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        bus.R = 4'b0100; bus.S = 2'd2; bus.IN_VALID = 1'b1;
        repeat (17) begin
            bus.D = $urandom;
            tick();
        end
        bus.IN_VALID = 1'b0;
        tick();
        chk("cnt2_wrap", N'(CNT2), 32'd1);
        chk("cnt0_zero", N'(CNT0), 32'd0);
        chk("cnt1_zero", N'(CNT1), 32'd0);
        chk("cnt3_zero", N'(CNT3), 32'd0);
`endif

        // Randomized traffic with occasional reset and ENABLE drops.
        for (int i = 0; i < 3000; i++) begin
            RESET_N      = ($urandom_range(0, 99) != 0);
            ENABLE       = ($urandom_range(0, 7) != 0);
            bus.IN_VALID = 1'($urandom_range(0, 1));
            bus.S        = 2'($urandom);
            bus.D        = $urandom;
            bus.R        = 4'($urandom);
            tick();
            if (q.size() > 1) chk("model_depth", N'(q.size()), 32'd1);
        end

        RESET_N = 1'b1;
        tick();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 The block SHALL have parameter N, default 32, which sets the data width in bits.
REQ-002 The block SHALL have parameter CW, default 16, which sets the transfer-counter width (used only with STREAM_DEMUX4_CNT_EN).
REQ-003 The block SHALL have the following ports.
- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- ENABLE  in  1  when low, no handshakes complete and state holds.
- IN_VALID  in  1  upstream word is present.
- IN_READY  out  1  block accepts the upstream word this cycle.
- S  in  2  destination select, sampled with D.
- D  in  N  upstream data word.
- V  out  4  per-destination valid; at most one bit set.
- R  in  4  per-destination ready.
- Y0, Y1, Y2, Y3  out  N each  destination data.
- CNT0..CNT3  out  CW each  per-destination completed-transfer counts (macro only).

Function
REQ-004 The block SHALL route each accepted word D to destination S; it is the registered inverse of the team's mux4 (S, D0..D3, Y).
REQ-005 The FSM SHALL have two states: IDLE (holding register empty) and HOLD (register full).
REQ-006 An input transfer SHALL occur when ENABLE && IN_VALID && IN_READY; on transfer, D is captured into data_q and S into sel_q.
REQ-007 IN_READY SHALL equal ENABLE && (state==IDLE || R[sel_q]), a combinational function of state and R only.
REQ-008 IN_READY SHALL NOT depend on IN_VALID.
REQ-009 In HOLD, V[sel_q] SHALL be 1 and all other V bits 0; in IDLE, V SHALL be 4'b0000.
REQ-010 In HOLD, Y[sel_q] SHALL equal data_q; the non-selected Y outputs SHALL be 0.
REQ-011 In IDLE, all Y outputs SHALL be 0.
REQ-012 An output transfer SHALL occur when ENABLE && state==HOLD && R[sel_q].
REQ-013 R bits of non-selected destinations SHALL be ignored.
REQ-014 The FSM SHALL transition IDLE->HOLD on an input transfer.
REQ-015 The FSM SHALL stay in HOLD, reloading data_q/sel_q, on a simultaneous output and input transfer (throughput 1 word/cycle).
REQ-016 The FSM SHALL transition HOLD->IDLE on an output transfer with no input transfer.
REQ-017 The FSM SHALL otherwise hold state.
REQ-018 Latency from input transfer to V assertion SHALL be exactly 1 cycle.
REQ-019 Once V[k] is asserted, data_q and sel_q SHALL remain stable until the output transfer completes (no retraction).
REQ-020 When ENABLE is low, IN_READY SHALL be 0, no transfer SHALL complete, and V/Y SHALL keep their current values.
REQ-021 A back-to-back transfer whose new S differs from sel_q SHALL switch V one-hot to the new destination in the next cycle, with no idle cycle.

Reset
REQ-022 When RESET_N is low at a rising CLOCK edge, the FSM SHALL enter IDLE and data_q, sel_q and CNT0..CNT3 SHALL clear to 0.
REQ-023 Reset SHALL take priority over ENABLE and over any handshake in the same cycle.
REQ-024 A word held in HOLD SHALL be discarded by reset.
REQ-025 During reset, V SHALL be 0, all Y SHALL be 0 and IN_READY SHALL be 0.

Configuration
REQ-026 With macro STREAM_DEMUX4_CNT_EN defined, ports CNT0..CNT3 SHALL exist, and CNTk SHALL increment by 1 on each output transfer to destination k.
REQ-027 CNTk SHALL wrap from 2^CW-1 to 0 with no saturation or flag.
REQ-028 Without STREAM_DEMUX4_CNT_EN, ports CNT0..CNT3 and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package stream_demux4_pkg SHALL hold the state enum (IDLE, HOLD), the default N=32 and CW=16 constants, and the select-width constant SW=2.
REQ-030 No sub-module SHALL be used except the optional xfer_counter (CW-bit, synchronous active-low clear, increment enable), instantiated four times under the macro.

Verification
REQ-031 The bench SHALL cover single transfer: reset, ENABLE=1, D=32'h00000005, S=2'b11, IN_VALID for 1 cycle, R=4'b1000 -> next cycle V=4'b1000, Y3=32'h5 and Y0..Y2=0, then IDLE.
REQ-032 The bench SHALL cover backpressure: hold D=32'h2 with S=2'b01 and R=0 for 5 cycles -> V=4'b0010 and Y1=32'h2 stable for 5 cycles and IN_READY=0; then R[1]=1 -> one transfer.
REQ-033 The bench SHALL cover streaming: IN_VALID held with D=1,2,3,5 and S=0,1,2,3, R=4'b1111 -> one word per cycle, appearing on V=0001,0010,0100,1000 in consecutive cycles.
REQ-034 The bench SHALL cover ENABLE: drop ENABLE in HOLD with R set -> no transfer and V held; raising ENABLE completes the transfer.
REQ-035 The bench SHALL cover reset mid-operation: RESET_N=0 while in HOLD with V=4'b0100 -> next cycle V=0, Y=0, IN_READY=0; after release, IN_READY=ENABLE.
REQ-036 The bench SHALL cover the counter with macro defined and CW=4: 17 transfers to destination 2 -> CNT2=1 (wrapped) and CNT0=CNT1=CNT3=0.
